// File: rtl/heepatia_fpga_pkg.sv
// Purpose: shared types and default constants for the heepatia FPGA boot/reset logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package heepatia_fpga_pkg;

  // Boot sequencer states; the encodings are visible on the debug port.
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2,
    DONE      = 2'd3
  } boot_seq_state_e;

  localparam int DEF_DEBOUNCE_CYCLES  = 1_000_000;
  localparam int DEF_LOCK_WAIT_CYCLES = 1024;
  localparam int DEF_RST_HOLD_CYCLES  = 256;
  localparam int DEF_BLINK_LENGTH     = 27;

endpackage

// File: rtl/fpga_debouncer.sv
// Purpose: 2-flop synchronizer + level debouncer for one board button, emitting a press pulse.
// Latency: press_o asserts 2 + CYCLES cycles after the raw edge, combinationally with the stable-level update.
// Backpressure: none; the pulse lasts one cycle and is not held.
//
// Ports:
//   clk_i, rst_i : single clock, synchronous active-high reset
//   in_i         : raw asynchronous button level (active-high)
//   press_o      : one-cycle pulse on a 0->1 transition of the debounced level
module fpga_debouncer
  import heepatia_fpga_pkg::*;
#(
  parameter int CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic press_o
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [1:0]    sync_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;
  logic          differ;
  logic          expire;

  assign differ = sync_q[1] ^ stable_q;
  // The counter has already seen CYCLES-1 differing cycles; this one completes the window.
  assign expire = differ && (cnt_q == CW'(CYCLES - 1));
  // Raised in the same cycle the stable level flips, so the consumer registers the
  // press on the same edge that the debouncer accepts the new level.
  assign press_o = expire && sync_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= 2'b00;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q <= {sync_q[0], in_i};
      if (!differ) begin
        cnt_q <= '0;
      end else if (expire) begin
        stable_q <= sync_q[1];
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fpga_boot_sequencer.sv
// Purpose: FPGA top-level boot sequencer: lock wait, SoC reset hold, strap latch, exit/LED decode.
// Latency: core_rst_no rises LOCK_WAIT_CYCLES + RST_HOLD_CYCLES edges after lock; exit results one edge after exit_valid_i.
// Backpressure: none; exit_valid_i is a level and is only consumed once per boot.
//
// Ports:
//   clk_i, rst_i                     : single clock, synchronous active-high reset
//   btn_rst_i                        : raw board reset button (async, active-high)
//   clk_locked_i                     : clock wizard lock
//   boot_select_sw_i, exec_flash_sw_i: raw strap switches (async)
//   exit_valid_i, exit_value_i       : SoC exit handshake
//   core_rst_no                      : registered active-low SoC reset
//   boot_select_o, execute_from_flash_o : straps latched on reset release
//   heartbeat_led_o, pass_led_o, fail_led_o, exit_value_o : status
//   state_o                          : FSM state for debug
module fpga_boot_sequencer
  import heepatia_fpga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int LOCK_WAIT_CYCLES = DEF_LOCK_WAIT_CYCLES,
  parameter int RST_HOLD_CYCLES  = DEF_RST_HOLD_CYCLES,
  parameter int BLINK_LENGTH     = DEF_BLINK_LENGTH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        btn_rst_i,
  input  logic        clk_locked_i,
  input  logic        boot_select_sw_i,
  input  logic        exec_flash_sw_i,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        core_rst_no,
  output logic        boot_select_o,
  output logic        execute_from_flash_o,
  output logic        heartbeat_led_o,
  output logic        pass_led_o,
  output logic        fail_led_o,
  output logic [31:0] exit_value_o,
  output logic [1:0]  state_o
);

  localparam int LCW = (LOCK_WAIT_CYCLES > 1) ? $clog2(LOCK_WAIT_CYCLES) : 1;
  localparam int HCW = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;

  boot_seq_state_e   state_q, state_d;
  logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [HCW-1:0]    hold_cnt_q, hold_cnt_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              boot_sel_q, boot_sel_d;
  logic              exec_flash_q, exec_flash_d;
  logic [31:0]       exit_val_q, exit_val_d;
  logic [BLINK_LENGTH-1:0] blink_q;
  logic [1:0]        boot_sync_q;
  logic [1:0]        flash_sync_q;
  logic              press;

  fpga_debouncer #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .in_i    (btn_rst_i),
    .press_o (press)
  );

  // Next-state / next-value logic. Priority: lock loss > press > exit capture > counters.
  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    core_rst_n_d = core_rst_n_q;
    boot_sel_d   = boot_sel_q;
    exec_flash_d = exec_flash_q;
    exit_val_d   = exit_val_q;

    if (!clk_locked_i) begin
      state_d      = WAIT_LOCK;
      lock_cnt_d   = '0;
      hold_cnt_d   = '0;
      core_rst_n_d = 1'b0;
      exit_val_d   = '0;
    end else if (press && (state_q != WAIT_LOCK)) begin
      // Straps are deliberately left alone; they re-latch on the next HOLD->RUN edge.
      state_d      = HOLD;
      hold_cnt_d   = '0;
      core_rst_n_d = 1'b0;
      exit_val_d   = '0;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          if (lock_cnt_q == LCW'(LOCK_WAIT_CYCLES - 1)) begin
            state_d    = HOLD;
            lock_cnt_d = '0;
            hold_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
          end
        end
        HOLD: begin
          if (hold_cnt_q == HCW'(RST_HOLD_CYCLES - 1)) begin
            // Straps and reset release land on the same edge so the SoC never
            // sees them change while it is out of reset.
            state_d      = RUN;
            hold_cnt_d   = '0;
            core_rst_n_d = 1'b1;
            boot_sel_d   = boot_sync_q[1];
            exec_flash_d = flash_sync_q[1];
          end else begin
            hold_cnt_d = hold_cnt_q + HCW'(1);
          end
        end
        RUN: begin
          if (exit_valid_i) begin
            state_d    = DONE;
            exit_val_d = exit_value_i;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = WAIT_LOCK;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= WAIT_LOCK;
      lock_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      core_rst_n_q <= 1'b0;
      boot_sel_q   <= 1'b0;
      exec_flash_q <= 1'b0;
      exit_val_q   <= '0;
      blink_q      <= '0;
      boot_sync_q  <= 2'b00;
      flash_sync_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      core_rst_n_q <= core_rst_n_d;
      boot_sel_q   <= boot_sel_d;
      exec_flash_q <= exec_flash_d;
      exit_val_q   <= exit_val_d;
      blink_q      <= blink_q + BLINK_LENGTH'(1);
      boot_sync_q  <= {boot_sync_q[0], boot_select_sw_i};
      flash_sync_q <= {flash_sync_q[0], exec_flash_sw_i};
    end
  end

  assign core_rst_no          = core_rst_n_q;
  assign boot_select_o        = boot_sel_q;
  assign execute_from_flash_o = exec_flash_q;
  assign exit_value_o         = exit_val_q;
  assign state_o              = state_q;
  assign heartbeat_led_o      = (state_q == RUN) && blink_q[BLINK_LENGTH-1];
  assign pass_led_o           = (state_q == DONE) && (exit_val_q == 32'd0);
  assign fail_led_o           = (state_q == DONE) && (exit_val_q != 32'd0);

endmodule
